// File: rtl/axis_gain_ramp_pkg.sv
// Shared constants for the N-channel AXI-Stream gain stage: register map,
// CTRL bit positions and the unity-gain helper.
package axis_gain_ramp_pkg;

    localparam logic [7:0] ADDR_CTRL        = 8'h00;
    localparam logic [7:0] ADDR_STEP        = 8'h01;
    localparam logic [7:0] ADDR_TARGET_BASE = 8'h02;

    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_RAMP_EN_BIT = 1;

    // Unity gain for a gain format with fbits fractional bits
    function automatic logic [31:0] unity_gain(input int unsigned fbits);
        return 32'd1 << fbits;
    endfunction

endpackage

// File: rtl/axis_gain_ramp_channel.sv
// One channel of the gain stage: current/target gain with linear ramp,
// multiply into S1, round and saturate into S2.
module axis_gain_ramp_channel
    import axis_gain_ramp_pkg::*;
#(
    parameter int unsigned AUDIO_WIDTH = 16,
    parameter int unsigned GAIN_WIDTH  = 16,
    parameter int unsigned GAIN_FBITS  = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          ramp_en,
    input  logic        [GAIN_WIDTH-1:0]  step,
    input  logic                          target_we,
    input  logic signed [GAIN_WIDTH-1:0]  target_wdata,
    input  logic                          accept,
    input  logic                          load_out,
    input  logic signed [AUDIO_WIDTH-1:0] sample,
    output logic signed [AUDIO_WIDTH-1:0] result,
    output logic                          busy_c
);

    localparam int unsigned PW = AUDIO_WIDTH + GAIN_WIDTH;
    // Two guard bits: cur + an unsigned full-range step cannot wrap
    localparam int unsigned RW = GAIN_WIDTH + 2;

    localparam logic signed [GAIN_WIDTH-1:0] UNITY    = GAIN_WIDTH'(unity_gain(GAIN_FBITS));
    localparam logic signed [PW-1:0]         HALF     = PW'(unity_gain(GAIN_FBITS - 1));
    localparam logic signed [PW-1:0]         SAT_MAX  = PW'((64'd1 << (AUDIO_WIDTH - 1)) - 64'd1);
    localparam logic signed [PW-1:0]         SAT_MIN  = ~SAT_MAX;

    logic signed [GAIN_WIDTH-1:0]  g_cur;
    logic signed [GAIN_WIDTH-1:0]  target;
    logic signed [GAIN_WIDTH-1:0]  g_nxt;
    logic signed [GAIN_WIDTH-1:0]  target_nxt;
    logic signed [GAIN_WIDTH-1:0]  g_use;
    logic signed [RW-1:0]          cur_w;
    logic signed [RW-1:0]          tgt_w;
    logic signed [RW-1:0]          step_w;
    logic signed [RW-1:0]          up_w;
    logic signed [RW-1:0]          dn_w;
    logic signed [PW-1:0]          prod_q;
    logic signed [PW-1:0]          prod_nxt;
    logic signed [PW-1:0]          rounded;
    logic signed [AUDIO_WIDTH-1:0] result_nxt;

    // Ramp update; the accepted frame itself uses the pre-update g_cur
    always_comb begin
        cur_w      = RW'(g_cur);
        tgt_w      = RW'(target);
        step_w     = $signed(RW'(step));
        up_w       = cur_w + step_w;
        dn_w       = cur_w - step_w;
        g_nxt      = g_cur;
        target_nxt = target_we ? target_wdata : target;
        if (accept && enable) begin
            if (!ramp_en || step == '0) begin
                g_nxt = target;
            end else if (g_cur < target) begin
                g_nxt = (up_w > tgt_w) ? target : GAIN_WIDTH'(up_w);
            end else if (g_cur > target) begin
                g_nxt = (dn_w < tgt_w) ? target : GAIN_WIDTH'(dn_w);
            end
        end
        busy_c = (g_nxt != target_nxt);
    end

    // Bypass multiplies by unity so round/saturate return the sample unchanged
    always_comb begin
        g_use    = enable ? g_cur : UNITY;
        prod_nxt = PW'(sample) * PW'(g_use);
        rounded  = (prod_q + HALF) >>> GAIN_FBITS;
        if (rounded > SAT_MAX) begin
            result_nxt = AUDIO_WIDTH'(SAT_MAX);
        end else if (rounded < SAT_MIN) begin
            result_nxt = AUDIO_WIDTH'(SAT_MIN);
        end else begin
            result_nxt = AUDIO_WIDTH'(rounded);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_cur  <= UNITY;
            target <= UNITY;
            prod_q <= '0;
            result <= '0;
        end else begin
            g_cur  <= g_nxt;
            target <= target_nxt;
            if (accept) begin
                prod_q <= prod_nxt;
            end
            if (load_out) begin
                result <= result_nxt;
            end
        end
    end

endmodule

// File: rtl/axis_gain_ramp.sv
// N-channel AXI-Stream gain stage with per-channel ramped gain. Owns the
// handshake, tlast pipeline and config registers; channels do the math.
module axis_gain_ramp
    import axis_gain_ramp_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned AUDIO_WIDTH = 16,
    parameter int unsigned GAIN_WIDTH  = 16,
    parameter int unsigned GAIN_FBITS  = 12
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_CH*AUDIO_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [NUM_CH*AUDIO_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic                          cfg_we,
    input  logic [7:0]                    cfg_addr,
    input  logic [31:0]                   cfg_wdata,
    output logic                          ramp_busy
);

    logic                  advance_c;
    logic                  accept_c;
    logic                  load_out_c;
    logic                  s1_valid;
    logic                  s1_last;
    logic [1:0]            ctrl;
    logic [GAIN_WIDTH-1:0] step;
    logic [NUM_CH-1:0]     target_we_c;
    logic [NUM_CH-1:0]     busy_c;
    logic                  unused_wdata;

    assign advance_c     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = advance_c;
    assign accept_c      = s_axis_tvalid && advance_c;
    assign load_out_c    = advance_c && s1_valid;
    assign unused_wdata  = &{1'b0, cfg_wdata[31:GAIN_WIDTH]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign target_we_c[c] = cfg_we && (cfg_addr == 8'(ADDR_TARGET_BASE + c));

        axis_gain_ramp_channel #(
            .AUDIO_WIDTH (AUDIO_WIDTH),
            .GAIN_WIDTH  (GAIN_WIDTH),
            .GAIN_FBITS  (GAIN_FBITS)
        ) u_ch (
            .clk          (aclk),
            .rst          (areset),
            .enable       (ctrl[CTRL_ENABLE_BIT]),
            .ramp_en      (ctrl[CTRL_RAMP_EN_BIT]),
            .step         (step),
            .target_we    (target_we_c[c]),
            .target_wdata (cfg_wdata[GAIN_WIDTH-1:0]),
            .accept       (accept_c),
            .load_out     (load_out_c),
            .sample       (s_axis_tdata[c*AUDIO_WIDTH +: AUDIO_WIDTH]),
            .result       (m_axis_tdata[c*AUDIO_WIDTH +: AUDIO_WIDTH]),
            .busy_c       (busy_c[c])
        );
    end

    // Config registers, valid/tlast pipeline and busy flag
    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl          <= '0;
            step          <= '0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            ramp_busy     <= 1'b0;
        end else begin
            if (cfg_we && cfg_addr == ADDR_CTRL) begin
                ctrl <= cfg_wdata[1:0];
            end
            if (cfg_we && cfg_addr == ADDR_STEP) begin
                step <= cfg_wdata[GAIN_WIDTH-1:0];
            end
            if (advance_c) begin
                s1_valid      <= s_axis_tvalid;
                m_axis_tvalid <= s1_valid;
            end
            if (accept_c) begin
                s1_last <= s_axis_tlast;
            end
            if (load_out_c) begin
                m_axis_tlast <= s1_last;
            end
            ramp_busy <= |busy_c;
        end
    end

endmodule
